// File: rtl/tcm_banked_ram.sv
// Multi-bank tightly-coupled memory shared by a fetch port (A) and a load/store port (B).
// Word addresses are interleaved across NBANK banks. Each bank is single-ported, so a
// same-bank collision is resolved by a round-robin arbiter, and those cycles are counted.
module tcm_banked_ram #(
   parameter int unsigned DW    = 32,
   parameter int unsigned MW    = 4,
   parameter int unsigned AW    = 14,
   parameter int unsigned NBANK = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_req_valid,
   output logic             a_req_ready,
   input  logic             a_req_we,
   input  logic [AW-1:0]    a_req_addr,
   input  logic [DW-1:0]    a_req_wdata,
   input  logic [MW-1:0]    a_req_wem,
   output logic             a_rsp_valid,
   input  logic             a_rsp_ready,
   output logic [DW-1:0]    a_rsp_rdata,
   input  logic             b_req_valid,
   output logic             b_req_ready,
   input  logic             b_req_we,
   input  logic [AW-1:0]    b_req_addr,
   input  logic [DW-1:0]    b_req_wdata,
   input  logic [MW-1:0]    b_req_wem,
   output logic             b_rsp_valid,
   input  logic             b_rsp_ready,
   output logic [DW-1:0]    b_rsp_rdata,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam int unsigned BW   = $clog2(NBANK);
   localparam int unsigned RW   = AW - BW;
   localparam int unsigned ROWS = 2 ** RW;

   // Replace any unknown bit with 0 so reads of never-written rows are clean.
   function automatic logic [DW-1:0] f_x2zero(input logic [DW-1:0] d);
      logic [DW-1:0] q;
      for (int unsigned i = 0; i < DW; i++) begin
         q[i] = (d[i] === 1'b1);
      end
      return q;
   endfunction

   logic             r_a_rsp_valid;
   logic [DW-1:0]    r_a_rsp_rdata;
   logic             r_b_rsp_valid;
   logic [DW-1:0]    r_b_rsp_rdata;
   logic             r_rr;
   logic [CNT_W-1:0] r_cnt;

   logic [BW-1:0]    w_bank_a;
   logic [BW-1:0]    w_bank_b;
   logic [RW-1:0]    w_row_a;
   logic [RW-1:0]    w_row_b;
   logic             w_free_a;
   logic             w_free_b;
   logic             w_want_a;
   logic             w_want_b;
   logic             w_conf;
   logic             w_acc_a;
   logic             w_acc_b;
   logic [DW-1:0]    w_bank_rd [NBANK];
   logic [DW-1:0]    w_a_rd;
   logic [DW-1:0]    w_b_rd;

   // Address decode: low bits pick the bank, high bits pick the row inside it.
   assign w_bank_a = a_req_addr[BW-1:0];
   assign w_bank_b = b_req_addr[BW-1:0];
   assign w_row_a  = a_req_addr[AW-1:BW];
   assign w_row_b  = b_req_addr[AW-1:BW];

   // A port can take a new request when its single response slot is empty or draining.
   assign w_free_a = !r_a_rsp_valid || a_rsp_ready;
   assign w_free_b = !r_b_rsp_valid || b_rsp_ready;
   assign w_want_a = a_req_valid && w_free_a && !rst;
   assign w_want_b = b_req_valid && w_free_b && !rst;
   assign w_conf   = w_want_a && w_want_b && (w_bank_a == w_bank_b);

   // Ready: the loser of a same-bank conflict is held off; nothing is accepted in reset.
   assign a_req_ready = !rst && w_free_a && !(w_conf && r_rr);
   assign b_req_ready = !rst && w_free_b && !(w_conf && !r_rr);
   assign w_acc_a     = a_req_valid && a_req_ready;
   assign w_acc_b     = b_req_valid && b_req_ready;

   for (genvar g = 0; g < NBANK; g++) begin : g_bank
      logic [DW-1:0] r_mem [ROWS];
      logic          w_sel_a;
      logic          w_sel_b;
      logic          w_we;
      logic [RW-1:0] w_row;
      logic [DW-1:0] w_wdata;
      logic [MW-1:0] w_wem;

      // Bank port mux: the arbiter guarantees at most one port selects this bank.
      assign w_sel_a = w_acc_a && (w_bank_a == BW'(g));
      assign w_sel_b = w_acc_b && (w_bank_b == BW'(g));
      assign w_row   = w_sel_b ? w_row_b : w_row_a;
      assign w_we    = (w_sel_a && a_req_we) || (w_sel_b && b_req_we);
      assign w_wdata = w_sel_b ? b_req_wdata : a_req_wdata;
      assign w_wem   = w_sel_b ? b_req_wem : a_req_wem;

      // Read-first: the returned word is the row content before this cycle's write.
      assign w_bank_rd[g] = r_mem[w_row];

      // Byte-masked write; memory contents are deliberately not reset.
      always_ff @(posedge clk) begin
         if (!rst && w_we) begin
            for (int unsigned i = 0; i < MW; i++) begin
               if (w_wem[i]) begin
                  r_mem[w_row][8*i +: 8] <= w_wdata[8*i +: 8];
               end
            end
         end
      end
   end

   assign w_a_rd = w_bank_rd[w_bank_a];
   assign w_b_rd = w_bank_rd[w_bank_b];

   // Port A response slot: load on accept, clear on retire, hold under back-pressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_rsp_valid <= 1'b0;
         r_a_rsp_rdata <= '0;
      end else if (w_acc_a) begin
         r_a_rsp_valid <= 1'b1;
         r_a_rsp_rdata <= f_x2zero(w_a_rd);
      end else if (a_rsp_ready) begin
         r_a_rsp_valid <= 1'b0;
      end
   end

   // Port B response slot: same behaviour as port A.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_b_rsp_valid <= 1'b0;
         r_b_rsp_rdata <= '0;
      end else if (w_acc_b) begin
         r_b_rsp_valid <= 1'b1;
         r_b_rsp_rdata <= f_x2zero(w_b_rd);
      end else if (b_rsp_ready) begin
         r_b_rsp_valid <= 1'b0;
      end
   end

   // Round-robin pointer flips after each conflict; saturating conflict counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr  <= 1'b0;
         r_cnt <= '0;
      end else if (w_conf) begin
         r_rr <= !r_rr;
         if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign a_rsp_valid  = r_a_rsp_valid;
   assign a_rsp_rdata  = r_a_rsp_rdata;
   assign b_rsp_valid  = r_b_rsp_valid;
   assign b_rsp_rdata  = r_b_rsp_rdata;
   assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_tcm_banked_ram.sv
// Directed and randomized bench for tcm_banked_ram with a flat-memory reference model.
module tb_tcm_banked_ram;

   localparam int unsigned DW    = 32;
   localparam int unsigned MW    = 4;
   localparam int unsigned AW    = 14;
   localparam int unsigned NBANK = 2;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned WIN   = 128;

   logic clk = 1'b0;
   logic rst;
   logic a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
   logic [AW-1:0] a_req_addr;
   logic [DW-1:0] a_req_wdata, a_rsp_rdata;
   logic [MW-1:0] a_req_wem;
   logic b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
   logic [AW-1:0] b_req_addr;
   logic [DW-1:0] b_req_wdata, b_rsp_rdata;
   logic [MW-1:0] b_req_wem;
   logic [CNT_W-1:0] conflict_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state: flat word memory over a test window plus per-port response slots.
   logic [DW-1:0] m_mem   [WIN];
   bit            m_known [WIN];
   bit            m_rr;
   int            m_cnt;
   bit            m_av, m_bv, m_ak, m_bk;
   logic [DW-1:0] m_ad, m_bd;

   tcm_banked_ram #(.DW(DW), .MW(MW), .AW(AW), .NBANK(NBANK), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_wem(a_req_wem),
      .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_wem(b_req_wem),
      .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; returns 1 time unit after the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic we, input logic [AW-1:0] ad,
                        input logic [DW-1:0] wd, input logic [MW-1:0] wm);
      a_req_valid = v; a_req_we = we; a_req_addr = ad; a_req_wdata = wd; a_req_wem = wm;
   endtask

   task automatic drv_b(input logic v, input logic we, input logic [AW-1:0] ad,
                        input logic [DW-1:0] wd, input logic [MW-1:0] wm);
      b_req_valid = v; b_req_we = we; b_req_addr = ad; b_req_wdata = wd; b_req_wem = wm;
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                           input logic [MW-1:0] wm);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < MW; i++) if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // One randomized cycle judged by the reference model (addresses inside the window).
   task automatic model_cycle(input bit av, input bit aw, input int ai, input logic [DW-1:0] ad,
                              input logic [MW-1:0] am, input bit ar,
                              input bit bv, input bit bw, input int bi, input logic [DW-1:0] bd,
                              input logic [MW-1:0] bm, input bit br);
      bit fa, fb, wa, wb, conf, ea, eb;
      logic [AW-1:0] aaddr, baddr;
      aaddr = AW'(256 + ai);
      baddr = AW'(256 + bi);
      drv_a(av, aw, aaddr, ad, am);
      drv_b(bv, bw, baddr, bd, bm);
      a_rsp_ready = ar;
      b_rsp_ready = br;
      #1;
      fa   = !m_av || ar;
      fb   = !m_bv || br;
      wa   = av && fa;
      wb   = bv && fb;
      conf = wa && wb && ((int'(aaddr) % NBANK) == (int'(baddr) % NBANK));
      ea   = fa && !(conf && m_rr);
      eb   = fb && !(conf && !m_rr);
      chk("rnd_a_req_ready", 64'(a_req_ready), 64'(ea));
      chk("rnd_b_req_ready", 64'(b_req_ready), 64'(eb));
      if (av && ea) begin
         m_av = 1; m_ad = m_mem[ai]; m_ak = m_known[ai];
      end else if (ar) m_av = 0;
      if (bv && eb) begin
         m_bv = 1; m_bd = m_mem[bi]; m_bk = m_known[bi];
      end else if (br) m_bv = 0;
      if (av && ea && aw) begin
         m_mem[ai] = merge(m_mem[ai], ad, am);
         m_known[ai] = m_known[ai] && 1'b1 && (m_known[ai] || am == '1);
         if (am == '1) m_known[ai] = 1;
      end
      if (bv && eb && bw) begin
         m_mem[bi] = merge(m_mem[bi], bd, bm);
         if (bm == '1) m_known[bi] = 1;
      end
      if (conf) begin
         m_rr = !m_rr;
         if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
      end
      step();
      chk("rnd_a_rsp_valid", 64'(a_rsp_valid), 64'(m_av));
      chk("rnd_b_rsp_valid", 64'(b_rsp_valid), 64'(m_bv));
      if (m_av && m_ak) chk("rnd_a_rsp_rdata", 64'(a_rsp_rdata), 64'(m_ad));
      if (m_bv && m_bk) chk("rnd_b_rsp_rdata", 64'(b_rsp_rdata), 64'(m_bd));
      chk("rnd_conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
   endtask

   initial begin
      rst = 1'b1;
      drv_a(0, 0, '0, '0, '0);
      drv_b(0, 0, '0, '0, '0);
      a_rsp_ready = 1'b1;
      b_rsp_ready = 1'b1;
      @(negedge clk); #1;

      // Reset and idle
      step();
      chk("rst_a_req_ready", 64'(a_req_ready), 64'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rst_a_rsp_valid", 64'(a_rsp_valid), 64'd0);
      chk("rst_b_rsp_valid", 64'(b_rsp_valid), 64'd0);
      chk("rst_a_rsp_rdata", 64'(a_rsp_rdata), 64'd0);
      chk("rst_b_rsp_rdata", 64'(b_rsp_rdata), 64'd0);
      chk("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
      chk("idle_a_req_ready", 64'(a_req_ready), 64'd1);
      chk("idle_b_req_ready", 64'(b_req_ready), 64'd1);

      // Byte-masked write then read
      drv_a(1, 1, AW'('h10), 32'h1122_3344, 4'hF);
      #1;
      chk("mask_wr1_ready", 64'(a_req_ready), 64'd1);
      step();
      chk("mask_wr1_rsp_valid", 64'(a_rsp_valid), 64'd1);
      drv_a(1, 1, AW'('h10), 32'h0000_AA00, 4'b0010);
      step();
      chk("mask_wr2_rsp_valid", 64'(a_rsp_valid), 64'd1);
      chk("mask_wr2_prewrite", 64'(a_rsp_rdata), 64'h1122_3344);
      drv_a(1, 0, AW'('h10), '0, '0);
      step();
      chk("mask_rd_rsp_valid", 64'(a_rsp_valid), 64'd1);
      chk("mask_rd_rdata", 64'(a_rsp_rdata), 64'h1122_AA44);
      drv_a(0, 0, '0, '0, '0);
      step();
      chk("mask_retire", 64'(a_rsp_valid), 64'd0);

      // Parallel banks (plus a setup write used later)
      drv_b(1, 1, AW'('h12), 32'hCAFE_F00D, 4'hF);
      step();
      drv_b(0, 0, '0, '0, '0);
      step();
      drv_a(1, 0, AW'('h20), '0, '0);
      drv_b(1, 0, AW'('h21), '0, '0);
      #1;
      chk("par_a_req_ready", 64'(a_req_ready), 64'd1);
      chk("par_b_req_ready", 64'(b_req_ready), 64'd1);
      step();
      chk("par_a_rsp_valid", 64'(a_rsp_valid), 64'd1);
      chk("par_b_rsp_valid", 64'(b_rsp_valid), 64'd1);
      chk("par_conflict_cnt", 64'(conflict_cnt), 64'd0);
      drv_a(0, 0, '0, '0, '0);
      drv_b(0, 0, '0, '0, '0);
      step();

      // Conflict round-robin: A,B,A,B
      drv_a(1, 0, AW'('h40), '0, '0);
      drv_b(1, 0, AW'('h42), '0, '0);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rr_a_req_ready", 64'(a_req_ready), 64'((i % 2) == 0));
         chk("rr_b_req_ready", 64'(b_req_ready), 64'((i % 2) == 1));
         step();
         chk("rr_a_rsp_valid", 64'(a_rsp_valid), 64'((i % 2) == 0));
         chk("rr_b_rsp_valid", 64'(b_rsp_valid), 64'((i % 2) == 1));
      end
      drv_a(0, 0, '0, '0, '0);
      drv_b(0, 0, '0, '0, '0);
      step();
      chk("rr_conflict_cnt", 64'(conflict_cnt), 64'd4);

      // Back-pressure on port A
      drv_a(1, 0, AW'('h10), '0, '0);
      step();
      chk("bp_rsp_valid", 64'(a_rsp_valid), 64'd1);
      a_rsp_ready = 1'b0;
      drv_a(1, 0, AW'('h12), '0, '0);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_req_ready_held", 64'(a_req_ready), 64'd0);
         step();
         chk("bp_rsp_valid_held", 64'(a_rsp_valid), 64'd1);
         chk("bp_rdata_held", 64'(a_rsp_rdata), 64'h1122_AA44);
      end
      a_rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(a_req_ready), 64'd1);
      step();
      chk("bp_next_rsp_valid", 64'(a_rsp_valid), 64'd1);
      chk("bp_next_rdata", 64'(a_rsp_rdata), 64'hCAFE_F00D);
      drv_a(0, 0, '0, '0, '0);
      step();

      // Reset mid-operation
      drv_b(1, 0, AW'('h12), '0, '0);
      step();
      chk("rmo_b_rsp_valid", 64'(b_rsp_valid), 64'd1);
      drv_b(0, 0, '0, '0, '0);
      b_rsp_ready = 1'b0;
      drv_a(1, 1, AW'('h10), 32'hFFFF_FFFF, 4'hF);
      rst = 1'b1;
      #1;
      chk("rmo_a_req_ready", 64'(a_req_ready), 64'd0);
      step();
      rst = 1'b0;
      drv_a(0, 0, '0, '0, '0);
      #1;
      chk("rmo_b_rsp_dropped", 64'(b_rsp_valid), 64'd0);
      chk("rmo_a_rsp_valid", 64'(a_rsp_valid), 64'd0);
      chk("rmo_conflict_cnt", 64'(conflict_cnt), 64'd0);
      b_rsp_ready = 1'b1;
      drv_a(1, 0, AW'('h10), '0, '0);
      step();
      chk("rmo_unchanged", 64'(a_rsp_rdata), 64'h1122_AA44);
      drv_a(0, 0, '0, '0, '0);
      step();

      // Randomized traffic against the reference model
      m_rr = 0; m_cnt = 0; m_av = 0; m_bv = 0; m_ak = 0; m_bk = 0; m_ad = '0; m_bd = '0;
      for (int i = 0; i < WIN; i++) begin
         m_mem[i] = '0;
         m_known[i] = 0;
      end
      for (int i = 0; i < WIN; i++) begin
         model_cycle(1, 1, i, DW'($urandom), 4'hF, 1, 0, 0, 0, '0, '0, 1);
      end
      for (int i = 0; i < 400; i++) begin
         model_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 7)), DW'($urandom), MW'($urandom),
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 7)), DW'($urandom), MW'($urandom),
                     $urandom_range(0, 3) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
